// File: rtl/instruction_fetch_data.sv
// instruction_fetch_data
//   Second instruction-fetch stage. Compares the tag-stage lookup result
//   against the fetch PC, reads the instruction data array on a hit, and
//   on a miss runs a full line refill from memory. When the refill is done
//   it tells the tag stage which tag to write and when to resume fetching.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   wb_do_branch        : flush/redirect; kills the hit in flight and any same-cycle miss
//   ift_valid/pc/valid_bits/tags : lookup result from the tag stage
//   ifd_cache_miss      : one-cycle pulse when a miss is accepted
//   ifd_update_tag_*    : tag write command to the tag stage (UPDATE cycle)
//   ifd_resume_fetch    : one-cycle pulse to restart fetch (RESUME cycle)
//   mem_rd_*            : line read request/response (4 beats, word order 0..3)
//   ifd_valid/pc/instr  : issued instruction to decode
module instruction_fetch_data #(
    parameter int NUM_WAYS   = 4,
    parameter int NUM_SETS   = 64,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 22
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_do_branch,
    input  logic                          ift_valid,
    input  logic [31:0]                   ift_pc,
    input  logic [NUM_WAYS-1:0]           ift_valid_bits,
    input  logic [NUM_WAYS*TAG_W-1:0]     ift_tags,
    output logic                          ifd_cache_miss,
    output logic [NUM_WAYS-1:0]           ifd_update_tag_en,
    output logic [$clog2(NUM_SETS)-1:0]   ifd_update_tag_set,
    output logic [TAG_W-1:0]              ifd_update_tag,
    output logic                          ifd_resume_fetch,
    output logic                          mem_rd_en,
    output logic [31:0]                   mem_rd_addr,
    input  logic                          mem_rd_ready,
    input  logic                          mem_rd_valid,
    input  logic [31:0]                   mem_rd_data,
    output logic                          ifd_valid,
    output logic [31:0]                   ifd_pc,
    output logic [31:0]                   ifd_instr
);

    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int SET_W  = $clog2(NUM_SETS);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int LINE_W = 32 - OFF_W;
    localparam int IDX_W  = SET_W + WAY_W + WORD_W;
    localparam int DEPTH  = NUM_SETS * NUM_WAYS * LINE_WORDS;

    typedef enum logic [2:0] {
        S_LOOKUP,
        S_REQ,
        S_FILL,
        S_UPDATE,
        S_RESUME
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   beat_q, beat_d;
    logic [WAY_W-1:0]    rr_q, rr_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic                used_rr_q, used_rr_d;
    logic                miss_q, miss_d;
    logic                valid_q, valid_d;
    logic [31:0]         pc_q;
    logic [31:0]         instr_q;

    logic [31:0]         data_q [DEPTH];

    logic [TAG_W-1:0]    pc_tag;
    logic [SET_W-1:0]    pc_set;
    logic [WORD_W-1:0]   pc_word;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic                inv_found;
    logic [WAY_W-1:0]    inv_way;
    logic                rd_en;
    logic                wr_en;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;
    logic                unused_pc_lsb;

    assign pc_tag        = ift_pc[31 -: TAG_W];
    assign pc_set        = ift_pc[OFF_W +: SET_W];
    assign pc_word       = ift_pc[2 +: WORD_W];
    assign unused_pc_lsb = ^ift_pc[1:0];

    // Tag compare and victim search; lowest-index way wins in both.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!hit && ift_valid_bits[w] && (ift_tags[w*TAG_W +: TAG_W] == pc_tag)) begin
                hit     = 1'b1;
                hit_way = w[WAY_W-1:0];
            end
            if (!inv_found && !ift_valid_bits[w]) begin
                inv_found = 1'b1;
                inv_way   = w[WAY_W-1:0];
            end
        end
    end

    assign rd_en  = (state_q == S_LOOKUP) && ift_valid && hit;
    assign rd_idx = {pc_set, hit_way, pc_word};
    assign wr_en  = (state_q == S_FILL) && mem_rd_valid;
    assign wr_idx = {line_q[SET_W-1:0], victim_q, beat_q};

    always_comb begin
        state_d            = state_q;
        beat_d             = beat_q;
        rr_d               = rr_q;
        line_d             = line_q;
        victim_d           = victim_q;
        used_rr_d          = used_rr_q;
        miss_d             = 1'b0;
        valid_d            = rd_en && !wb_do_branch;
        mem_rd_en          = 1'b0;
        mem_rd_addr        = '0;
        ifd_update_tag_en  = '0;
        ifd_update_tag_set = '0;
        ifd_update_tag     = '0;
        ifd_resume_fetch   = 1'b0;
        unique case (state_q)
            S_LOOKUP: begin
                if (ift_valid && !hit && !wb_do_branch) begin
                    miss_d    = 1'b1;
                    line_d    = ift_pc[31:OFF_W];
                    victim_d  = inv_found ? inv_way : rr_q;
                    used_rr_d = !inv_found;
                    beat_d    = '0;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = {line_q, {OFF_W{1'b0}}};
                if (mem_rd_ready) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_rd_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == WORD_W'(LINE_WORDS - 1)) begin
                        state_d = S_UPDATE;
                    end
                end
            end
            S_UPDATE: begin
                ifd_update_tag_en[victim_q] = 1'b1;
                ifd_update_tag_set          = line_q[SET_W-1:0];
                ifd_update_tag              = line_q[LINE_W-1 -: TAG_W];
                // Round-robin advances only once a refill that used it completes.
                if (used_rr_q) begin
                    rr_d = rr_q + 1'b1;
                end
                state_d = S_RESUME;
            end
            S_RESUME: begin
                ifd_resume_fetch = 1'b1;
                state_d          = S_LOOKUP;
            end
            default: state_d = S_LOOKUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_LOOKUP;
            beat_q    <= '0;
            rr_q      <= '0;
            line_q    <= '0;
            victim_q  <= '0;
            used_rr_q <= 1'b0;
            miss_q    <= 1'b0;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            rr_q      <= rr_d;
            line_q    <= line_d;
            victim_q  <= victim_d;
            used_rr_q <= used_rr_d;
            miss_q    <= miss_d;
            valid_q   <= valid_d;
            if (rd_en) begin
                pc_q    <= ift_pc;
                instr_q <= data_q[rd_idx];
            end
        end
    end

    // Data array is not reset; a partial line left by reset is harmless
    // because its tag is never written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx] <= mem_rd_data;
        end
    end

    assign ifd_cache_miss = miss_q;
    assign ifd_valid      = valid_q;
    assign ifd_pc         = pc_q;
    assign ifd_instr      = instr_q;

endmodule

// File: tb/tb_instruction_fetch_data.sv
module tb_instruction_fetch_data;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_do_branch;
    logic        ift_valid;
    logic [31:0] ift_pc;
    logic [3:0]  ift_valid_bits;
    logic [87:0] ift_tags;
    logic        ifd_cache_miss;
    logic [3:0]  ifd_update_tag_en;
    logic [5:0]  ifd_update_tag_set;
    logic [21:0] ifd_update_tag;
    logic        ifd_resume_fetch;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ready;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        ifd_valid;
    logic [31:0] ifd_pc;
    logic [31:0] ifd_instr;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    instruction_fetch_data #(
        .NUM_WAYS(4),
        .NUM_SETS(64),
        .LINE_WORDS(4),
        .TAG_W(22)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb_do_branch(wb_do_branch),
        .ift_valid(ift_valid),
        .ift_pc(ift_pc),
        .ift_valid_bits(ift_valid_bits),
        .ift_tags(ift_tags),
        .ifd_cache_miss(ifd_cache_miss),
        .ifd_update_tag_en(ifd_update_tag_en),
        .ifd_update_tag_set(ifd_update_tag_set),
        .ifd_update_tag(ifd_update_tag),
        .ifd_resume_fetch(ifd_resume_fetch),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_ready(mem_rd_ready),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data),
        .ifd_valid(ifd_valid),
        .ifd_pc(ifd_pc),
        .ifd_instr(ifd_instr)
    );

    function automatic logic [87:0] pack4(input logic [21:0] t0, t1, t2, t3);
        return {t3, t2, t1, t0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one lookup that must miss, then confirm the miss pulse and request.
    task automatic do_miss(input logic [31:0] pc, input logic [3:0] vb, input logic [87:0] tg);
        ift_valid      = 1'b1;
        ift_pc         = pc;
        ift_valid_bits = vb;
        ift_tags       = tg;
        tick();
        ift_valid = 1'b0;
        chk("miss_pulse", 32'(ifd_cache_miss), 32'd1);
        chk("miss_rd_en", 32'(mem_rd_en), 32'd1);
        chk("miss_rd_addr", mem_rd_addr, {pc[31:4], 4'b0});
    endtask

    // Zero-wait refill: accept request, then four back-to-back beats base+0..3.
    // Returns with the DUT in its UPDATE cycle.
    task automatic refill(input logic [31:0] base);
        mem_rd_ready = 1'b1;
        tick();
        mem_rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = base + 32'(i);
            tick();
        end
        mem_rd_valid = 1'b0;
    endtask

    task automatic hit_lookup(input logic [31:0] pc, input logic [3:0] vb, input logic [87:0] tg);
        ift_valid      = 1'b1;
        ift_pc         = pc;
        ift_valid_bits = vb;
        ift_tags       = tg;
        tick();
        ift_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        wb_do_branch   = 1'b0;
        ift_valid      = 1'b0;
        ift_pc         = '0;
        ift_valid_bits = '0;
        ift_tags       = '0;
        mem_rd_ready   = 1'b0;
        mem_rd_valid   = 1'b0;
        mem_rd_data    = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(ifd_valid), 32'd0);
        chk("rst_miss", 32'(ifd_cache_miss), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_rd_addr", mem_rd_addr, 32'd0);
        chk("rst_upd_en", 32'(ifd_update_tag_en), 32'd0);
        chk("rst_resume", 32'(ifd_resume_fetch), 32'd0);
        chk("rst_pc", ifd_pc, 32'd0);
        chk("rst_instr", ifd_instr, 32'd0);

        // Cold miss at PC 0, request held while not ready, beats with a gap
        do_miss(32'h0, 4'b0000, '0);
        tick();
        chk("cold_miss_once", 32'(ifd_cache_miss), 32'd0);
        chk("cold_req_hold", 32'(mem_rd_en), 32'd1);
        mem_rd_ready = 1'b1;
        tick();
        mem_rd_ready = 1'b0;
        chk("cold_req_drop", 32'(mem_rd_en), 32'd0);
        mem_rd_valid = 1'b1; mem_rd_data = 32'h11; tick();
        mem_rd_valid = 1'b1; mem_rd_data = 32'h22; tick();
        mem_rd_valid = 1'b0; tick();
        chk("cold_gap_no_upd", 32'(ifd_update_tag_en), 32'd0);
        mem_rd_valid = 1'b1; mem_rd_data = 32'h33; tick();
        mem_rd_valid = 1'b1; mem_rd_data = 32'h44; tick();
        mem_rd_valid = 1'b0;
        chk("cold_upd_en", 32'(ifd_update_tag_en), 32'b0001);
        chk("cold_upd_set", 32'(ifd_update_tag_set), 32'd0);
        chk("cold_upd_tag", 32'(ifd_update_tag), 32'd0);
        chk("cold_upd_no_resume", 32'(ifd_resume_fetch), 32'd0);
        tick();
        chk("cold_resume", 32'(ifd_resume_fetch), 32'd1);
        chk("cold_resume_no_upd", 32'(ifd_update_tag_en), 32'd0);
        tick();
        chk("cold_resume_once", 32'(ifd_resume_fetch), 32'd0);

        // Hits after refill, back to back
        ift_valid = 1'b1; ift_pc = 32'h8; ift_valid_bits = 4'b0001; ift_tags = '0;
        tick();
        chk("hit8_valid", 32'(ifd_valid), 32'd1);
        chk("hit8_pc", ifd_pc, 32'h8);
        chk("hit8_instr", ifd_instr, 32'h33);
        ift_pc = 32'hC;
        tick();
        chk("hitC_valid", 32'(ifd_valid), 32'd1);
        chk("hitC_pc", ifd_pc, 32'hC);
        chk("hitC_instr", ifd_instr, 32'h44);
        ift_valid = 1'b0;
        tick();
        chk("hit_idle_valid", 32'(ifd_valid), 32'd0);

        // Miss at PC 0x10 with ways 0..2 valid (other tags): victim is way 3
        do_miss(32'h10, 4'b0111, pack4(22'd1, 22'd2, 22'd3, 22'd0));
        refill(32'hA0);
        chk("w3_upd_en", 32'(ifd_update_tag_en), 32'b1000);
        chk("w3_upd_set", 32'(ifd_update_tag_set), 32'd1);
        chk("w3_upd_tag", 32'(ifd_update_tag), 32'd0);
        tick();
        tick();
        hit_lookup(32'h14, 4'b1000, '0);
        chk("w3_hit_valid", 32'(ifd_valid), 32'd1);
        chk("w3_hit_instr", ifd_instr, 32'hA1);

        // All ways valid: three misses to set 2 take ways 0,1,2 round-robin
        for (int k = 0; k < 3; k++) begin
            do_miss(32'h20, 4'b1111, pack4(22'd1, 22'd2, 22'd3, 22'd4));
            refill(32'hB00 + 32'(k * 16));
            chk("rr_upd_en", 32'(ifd_update_tag_en), 32'd1 << k);
            chk("rr_upd_set", 32'(ifd_update_tag_set), 32'd2);
            tick();
            tick();
        end
        // Two matching ways: lowest (way 1) supplies the data
        hit_lookup(32'h24, 4'b0110, '0);
        chk("multi_hit_valid", 32'(ifd_valid), 32'd1);
        chk("multi_hit_instr", ifd_instr, 32'hB11);

        // Branch kills a hit in flight and suppresses a same-cycle miss
        wb_do_branch = 1'b1;
        hit_lookup(32'h8, 4'b0001, '0);
        chk("br_hit_killed", 32'(ifd_valid), 32'd0);
        hit_lookup(32'h40, 4'b0000, '0);
        chk("br_no_miss", 32'(ifd_cache_miss), 32'd0);
        chk("br_no_req", 32'(mem_rd_en), 32'd0);
        wb_do_branch = 1'b0;

        // Branch during FILL: refill still completes
        do_miss(32'h30, 4'b0000, '0);
        mem_rd_ready = 1'b1; tick(); mem_rd_ready = 1'b0;
        mem_rd_valid = 1'b1; mem_rd_data = 32'h300; tick();
        wb_do_branch = 1'b1; mem_rd_data = 32'h301; tick();
        wb_do_branch = 1'b0; mem_rd_data = 32'h302; tick();
        mem_rd_data = 32'h303; tick();
        mem_rd_valid = 1'b0;
        chk("brfill_upd_en", 32'(ifd_update_tag_en), 32'b0001);
        chk("brfill_upd_set", 32'(ifd_update_tag_set), 32'd3);
        tick();
        chk("brfill_resume", 32'(ifd_resume_fetch), 32'd1);
        tick();

        // Reset during FILL after two beats
        do_miss(32'h50, 4'b0000, '0);
        mem_rd_ready = 1'b1; tick(); mem_rd_ready = 1'b0;
        mem_rd_valid = 1'b1; mem_rd_data = 32'h500; tick();
        mem_rd_data = 32'h501; tick();
        mem_rd_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_miss", 32'(ifd_cache_miss), 32'd0);
        chk("midrst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("midrst_rd_addr", mem_rd_addr, 32'd0);
        chk("midrst_upd_en", 32'(ifd_update_tag_en), 32'd0);
        chk("midrst_resume", 32'(ifd_resume_fetch), 32'd0);
        chk("midrst_valid", 32'(ifd_valid), 32'd0);
        chk("midrst_instr", ifd_instr, 32'd0);
        tick();
        chk("midrst_idle_upd", 32'(ifd_update_tag_en), 32'd0);
        chk("midrst_idle_rd_en", 32'(mem_rd_en), 32'd0);
        do_miss(32'h50, 4'b0000, '0);
        refill(32'hC0);
        chk("remiss_upd_en", 32'(ifd_update_tag_en), 32'b0001);
        chk("remiss_upd_set", 32'(ifd_update_tag_set), 32'd5);
        tick();
        tick();
        hit_lookup(32'h58, 4'b0001, '0);
        chk("remiss_hit_instr", ifd_instr, 32'hC2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_data.md
# instruction_fetch_data

Second stage of the instruction fetch pipeline, directly downstream of `instruction_fetch_tag`. It takes the tag-stage lookup result (PC, per-way tags and valid bits) and compares tags to find a hit. On a hit it reads the 4-way instruction data array and issues one instruction per cycle to decode. On a miss it runs the line refill from memory, then tells the tag stage which tag to write and when to resume fetching.

## Interface
Parameters:
- `NUM_WAYS`, 4: associativity.
- `NUM_SETS`, 64: sets. Set index is PC[9:4].
- `LINE_WORDS`, 4: 32-bit words per line. Word offset is PC[3:2].
- `TAG_W`, 22: tag width, PC[31:10].

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `wb_do_branch` in 1: pipeline flush / redirect from writeback.
- `ift_valid` in 1: tag-stage output valid.
- `ift_pc` in 32: fetch PC.
- `ift_valid_bits` in NUM_WAYS: valid bit per way for the fetched set.
- `ift_tags` in NUM_WAYS*TAG_W: stored tags for the set; way w is at [w*TAG_W +: TAG_W].
- `ifd_cache_miss` out 1: one-cycle pulse when a miss is detected.
- `ifd_update_tag_en` out NUM_WAYS: one-hot way whose tag the tag stage writes.
- `ifd_update_tag_set` out 6: set to update.
- `ifd_update_tag` out TAG_W: tag value to write.
- `ifd_resume_fetch` out 1: one-cycle pulse; the tag stage restarts fetch.
- `mem_rd_en` out 1: line read request.
- `mem_rd_addr` out 32: line-aligned address, low 4 bits zero.
- `mem_rd_ready` in 1: memory accepts the request.
- `mem_rd_valid` in 1: data beat valid.
- `mem_rd_data` in 32: data beat, word order 0..3.
- `ifd_valid` out 1: instruction valid to decode.
- `ifd_pc` out 32: PC of the issued instruction.
- `ifd_instr` out 32: issued instruction.

## Operation
- Reset: every output is 0. State is LOOKUP, beat counter is 0, replacement counter is 0.
- The data array is NUM_SETS×NUM_WAYS×LINE_WORDS×32 with synchronous read. It is not reset; contents are only meaningful when the matching tag is valid.
- **LOOKUP** (ift_valid=1):
  - Hit when any way has `ift_valid_bits[w]` set and its tag equals `ift_pc[31:10]`. Multiple matches are illegal; the lowest way wins.
  - On a hit, register the hit way and PC, and read the array at {set, word}.
  - On a miss, pulse `ifd_cache_miss`, latch PC[31:4] and the victim way, and go to REQ.
- **Victim way:** the lowest-index invalid way. If all ways are valid, use the 2-bit round-robin counter. The counter increments after every refill that used it.
- **REQ:** hold `mem_rd_en`=1 with `mem_rd_addr`={PC[31:4],4'b0} until `mem_rd_ready`=1, then go to FILL.
- **FILL:**
  - Each `mem_rd_valid` writes `mem_rd_data` to the victim way at word = beat count.
  - After beat 3, go to UPDATE.
  - Beats may arrive with gaps. Beats seen outside FILL are ignored.
- **UPDATE:** one cycle with `ifd_update_tag_en`=onehot(victim), `ifd_update_tag_set`=PC[9:4], `ifd_update_tag`=PC[31:10]. Then go to RESUME.
- **RESUME:** one cycle with `ifd_resume_fetch`=1. Then go to LOOKUP.
- In every state other than LOOKUP, `ift_valid` is ignored. No hit output is produced.
- **`wb_do_branch`:**
  - Clears any hit in flight, so `ifd_valid`=0 the next cycle.
  - In LOOKUP it also suppresses a same-cycle miss: no pulse, no refill.
  - During REQ, FILL or UPDATE the refill runs to completion, because the memory transaction cannot be cancelled. UPDATE and RESUME still occur.

## Timing
- Hit latency is 1 cycle: `ift_valid` at cycle N gives `ifd_valid`/`ifd_pc`/`ifd_instr` at N+1.
- Back-to-back hits give one instruction per cycle.
- Miss: `ifd_cache_miss` is high in cycle N+1 only. `mem_rd_en` rises in N+1.
- Request-to-UPDATE: UPDATE is the cycle after the 4th beat. RESUME is the cycle after UPDATE.
- With zero-wait memory (ready at N+1, beats at N+2..N+5), UPDATE is at N+6 and RESUME at N+7.
- `ifd_update_tag_en` and `ifd_resume_fetch` are never high in the same cycle.
- `rst` mid-refill: the next cycle is LOOKUP with all outputs 0. A partial line stays in the data array but no tag is written.

## Test plan
- **Cold miss at PC 0x0, all valid bits 0:**
  - `ifd_cache_miss` pulses once; `mem_rd_addr`=0x0.
  - Beats 0x11,0x22,0x33,0x44 give `ifd_update_tag_en`=4'b0001, set 0, tag 0, then `ifd_resume_fetch` for one cycle.
- **Hit after refill:** ift_pc=0x8, valid_bits=0001, tag0=0 → next cycle `ifd_valid`=1, `ifd_pc`=0x8, `ifd_instr`=0x33.
- **Miss at PC 0x10 with valid_bits=0111:** victim way 3 → `ifd_update_tag_en`=4'b1000, `ifd_update_tag_set`=1.
- **All ways valid, three misses to set 2:** victims are way 0, 1, 2 in order (round-robin from reset).
- **`wb_do_branch` with a hit in flight:** `ifd_valid`=0 the next cycle. Branch during FILL: refill completes and UPDATE/RESUME still pulse.
- **`rst` during FILL after 2 beats:** all outputs 0 and state LOOKUP. A following lookup of the same PC with valid_bits=0 misses again.
